// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath widths, default fetch window
// and reset vector, fetch FSM states and the fetch-queue entry layout.
package mips_pkg;

  localparam int ADDR_W = 30;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 30'h00100000;
  localparam logic [ADDR_W-1:0] DEF_MEM_LO   = 30'h00100000;
  localparam logic [ADDR_W-1:0] DEF_MEM_HI   = 30'h00100100;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO between instruction memory and decode.
// Only the occupancy count is reset; entry storage is qualified by the count,
// so the data registers carry no reset.
module fetch_queue
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count;
  fetch_entry_t ent0;
  fetch_entry_t ent1;

  assign head  = ent0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Occupancy: flush wins, simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (push && !pop) begin
      count <= count + 2'd1;
    end else if (pop && !push) begin
      count <= count - 2'd1;
    end
  end

  // Entry storage: a pop shifts entry 1 down, a push lands in the first free slot
  // after that shift.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pop) begin
        ent0 <= (push && count == 2'd1) ? din : ent1;
        if (push && count == 2'd2) begin
          ent1 <= din;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          ent0 <= din;
        end else begin
          ent1 <= din;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads instruction memory and feeds
// decode through a two-entry queue. Redirects flush the queue and retarget the PC.
// Optional window check on the PC is enabled with `define FETCH_BOUNDS_CHECK_EN;
// without it the PC is never illegal and fault is tied low.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0] MEM_LO   = DEF_MEM_LO,
  parameter logic [ADDR_W-1:0] MEM_HI   = DEF_MEM_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  output logic              fault
);

  // An inverted window is a configuration error, caught at elaboration.
  if (MEM_LO > MEM_HI) begin : g_bad_window
    $error("fetch_sequencer: MEM_LO above MEM_HI");
  end

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  fetch_entry_t      q_head;
  fetch_entry_t      q_din;

  assign pop      = !q_empty && if_ready;
  assign q_din    = '{inst: imem_inst, pc: pc};
  assign imem_pc  = pc;
  assign if_valid = !q_empty;
  assign if_inst  = if_valid ? q_head.inst : '0;
  assign if_pc    = if_valid ? q_head.pc   : '0;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic in_window;
  assign in_window = (pc >= MEM_LO) && (pc <= MEM_HI);
  assign fault     = (state == FAULT);
`else
  assign fault     = 1'b0;
`endif

  // PC and fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Redirect beats everything; otherwise fetch while running, enabled and not blocked.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    if (redirect_valid) begin
      state_nxt = RUN;
      pc_nxt    = redirect_pc;
    end else if (state == RUN && fetch_en) begin
`ifdef FETCH_BOUNDS_CHECK_EN
      if (!in_window) begin
        state_nxt = FAULT;
      end else if (!q_full || pop) begin
        push   = 1'b1;
        pc_nxt = pc + 1'b1;
      end
`else
      if (!q_full || pop) begin
        push   = 1'b1;
        pc_nxt = pc + 1'b1;
      end
`endif
    end
  end

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule
